keypad_scanner: RTL

//  Scans a 4x4 matrix keypad and produces the debounced 5-bit key code consumed by the calculator control FSM.

---
 rtl/keypad_scanner.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with frame decode and debounce
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   row[3:0]   keypad rows, active-low, asynchronous to clk
//   col[3:0]   active-low one-hot column drive
//   key[4:0]   debounced key code (0..15, 16 = none)
//   key_valid  one-cycle pulse when key commits to a new pressed code
//   multi      last completed frame saw two or more keys
module keypad_scanner #(
    parameter int SCAN_DIV = 10000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [4:0] key,
    output logic       key_valid,
    output logic       multi
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int STB_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE);
    localparam logic [4:0]       KEY_NONE = 5'd16;

    // Hit index is {row, col}; returns the legend printed on that key.
    function automatic logic [4:0] map_code(input logic [3:0] idx);
        logic [4:0] code;
        case (idx)
            4'd0:    code = 5'd1;
            4'd1:    code = 5'd2;
            4'd2:    code = 5'd3;
            4'd3:    code = 5'd10;
            4'd4:    code = 5'd4;
            4'd5:    code = 5'd5;
            4'd6:    code = 5'd6;
            4'd7:    code = 5'd11;
            4'd8:    code = 5'd7;
            4'd9:    code = 5'd8;
            4'd10:   code = 5'd9;
            4'd11:   code = 5'd12;
            4'd12:   code = 5'd14;
            4'd13:   code = 5'd0;
            4'd14:   code = 5'd15;
            default: code = 5'd13;
        endcase
        return code;
    endfunction

    logic [3:0]       row_meta_q, row_meta_d;
    logic [3:0]       row_sync_q, row_sync_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [15:0]      hits_q, hits_d;
    logic [4:0]       cand_q, cand_d;
    logic [STB_W-1:0] stable_q, stable_d;
    logic             commit_q, commit_d;
    logic [4:0]       key_q, key_d;
    logic             key_valid_q, key_valid_d;
    logic             multi_q, multi_d;

    logic             sample;
    logic             frame_close;
    logic [15:0]      slot_hits;
    logic [15:0]      frame_hits;
    logic [4:0]       hit_cnt;
    logic [4:0]       hit_code;
    logic [4:0]       raw_code;

    always_comb begin
        row_meta_d  = row;
        row_sync_d  = row_meta_q;

        sample      = (div_q == DIV_LAST);
        frame_close = sample && (col_idx_q == 2'd3);
        div_d       = sample ? '0 : div_q + 1'b1;
        col_idx_d   = sample ? col_idx_q + 2'd1 : col_idx_q;

        for (int i = 0; i < 16; i++) begin
            slot_hits[i] = (i[1:0] == col_idx_q) && !row_sync_q[i[3:2]];
        end
        // The closing slot's hits are folded in combinationally so the
        // frame decodes in the same cycle as its last sample.
        frame_hits = hits_q | (sample ? slot_hits : 16'h0000);

        hit_cnt  = 5'd0;
        hit_code = KEY_NONE;
        for (int i = 0; i < 16; i++) begin
            if (frame_hits[i]) begin
                hit_cnt  = hit_cnt + 5'd1;
                hit_code = map_code(i[3:0]);
            end
        end
        raw_code = (hit_cnt == 5'd1) ? hit_code : KEY_NONE;

        hits_d   = frame_close ? 16'h0000 : frame_hits;
        multi_d  = frame_close ? (hit_cnt > 5'd1) : multi_q;

        cand_d   = cand_q;
        stable_d = stable_q;
        commit_d = 1'b0;
        if (frame_close) begin
            if (raw_code != cand_q) begin
                cand_d   = raw_code;
                stable_d = STB_W'(1);
            end else if (stable_q != STB_MAX) begin
                stable_d = stable_q + 1'b1;
            end
            // Saturation keeps this true while a key is held; the
            // resulting recommit of an unchanged code cannot pulse.
            commit_d = (stable_d == STB_MAX);
        end

        key_d       = key_q;
        key_valid_d = 1'b0;
        if (commit_q) begin
            key_d       = cand_q;
            key_valid_d = (cand_q != key_q) && (cand_q != KEY_NONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            div_q       <= '0;
            col_idx_q   <= 2'd0;
            hits_q      <= 16'h0000;
            cand_q      <= KEY_NONE;
            stable_q    <= '0;
            commit_q    <= 1'b0;
            key_q       <= KEY_NONE;
            key_valid_q <= 1'b0;
            multi_q     <= 1'b0;
        end else begin
            row_meta_q  <= row_meta_d;
            row_sync_q  <= row_sync_d;
            div_q       <= div_d;
            col_idx_q   <= col_idx_d;
            hits_q      <= hits_d;
            cand_q      <= cand_d;
            stable_q    <= stable_d;
            commit_q    <= commit_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            multi_q     <= multi_d;
        end
    end

    assign col       = ~(4'b0001 << col_idx_q);
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign multi     = multi_q;

endmodule
